// File: rtl/count_delta_sampler_pkg.sv
// Shared types for the count delta sampler: sample width, drop tally width and priming states.
package count_sampler_pkg;
   localparam int COUNT_W = 16;
   localparam int DROP_W  = 8;

   typedef logic [COUNT_W-1:0] count_t;

   typedef enum logic {UNPRIMED = 1'b0, PRIMED = 1'b1} prime_state_t;
endpackage

// File: rtl/count_delta_sampler_fifo2.sv
// Two-entry in-order register FIFO; a push is refused when full before this cycle's pop.
// Head is zero while empty so the consumer never sees stale data.
module sampler_fifo2
   import count_sampler_pkg::*;
(
   input  logic               CLK,
   input  logic               ASYNCRESETN,
   input  logic               i_push,
   input  logic [COUNT_W-1:0] i_dat,
   input  logic               i_pop,
   output logic               o_full,
   output logic               o_empty,
   output logic [COUNT_W-1:0] o_head
);
   logic [1:0] r_occ;
   count_t     r_mem0;
   count_t     r_mem1;
   logic       w_pop;
   logic       w_push;

   assign w_pop   = i_pop && (r_occ != 2'd0);
   assign w_push  = i_push && (r_occ != 2'd2);
   assign o_full  = (r_occ == 2'd2);
   assign o_empty = (r_occ == 2'd0);
   assign o_head  = (r_occ != 2'd0) ? r_mem0 : '0;

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_occ  <= 2'd0;
         r_mem0 <= '0;
         r_mem1 <= '0;
      end else begin
         case (r_occ)
            2'd0: begin
               if (w_push) begin
                  r_mem0 <= i_dat;
                  r_occ  <= 2'd1;
               end
            end
            2'd1: begin
               // push and pop together: the new entry becomes the head directly
               if (w_push && w_pop) begin
                  r_mem0 <= i_dat;
               end else if (w_push) begin
                  r_mem1 <= i_dat;
                  r_occ  <= 2'd2;
               end else if (w_pop) begin
                  r_occ  <= 2'd0;
               end
            end
            default: begin
               if (w_pop) begin
                  r_mem0 <= r_mem1;
                  r_occ  <= 2'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: rtl/count_delta_sampler.sv
// Samples an upstream running count every PERIOD enabled cycles and streams wrap-aware deltas
// through a 2-deep buffer; samples arriving while the buffer is full are dropped and tallied.
module count_delta_sampler
   import count_sampler_pkg::*;
#(
   parameter int PERIOD = 4
)(
   input  logic               CLK,
   input  logic               ASYNCRESETN,
   input  logic [COUNT_W-1:0] count_in,
   input  logic               en,
   input  logic               clr_stats,
   output logic [COUNT_W-1:0] delta_out,
   output logic               delta_valid,
   input  logic               delta_ready,
   output logic               dropped,
   output logic [DROP_W-1:0]  drop_count
);
   localparam int TMR_W = $clog2(PERIOD);

   logic [TMR_W-1:0]  r_timer;
   prime_state_t      r_state;
   count_t            r_baseline;
   logic              r_dropped;
   logic [DROP_W-1:0] r_drop_cnt;

   logic              w_tick;
   logic              w_push;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;
   count_t            w_delta;
   logic [DROP_W-1:0] w_cnt_base;

   assign w_tick  = en && (r_timer == TMR_W'(PERIOD - 1));
   assign w_push  = w_tick && (r_state == PRIMED);
   assign w_delta = count_in - r_baseline;
   assign w_drop  = w_push && w_full;

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_timer <= '0;
      end else if (!en || w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TMR_W'(1);
      end
   end

   // Baseline advances on every tick, including drops, so each delta spans one window.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_state    <= UNPRIMED;
         r_baseline <= '0;
      end else if (!en) begin
         r_state    <= UNPRIMED;
      end else if (w_tick) begin
         r_state    <= PRIMED;
         r_baseline <= count_in;
      end
   end

   assign w_cnt_base = clr_stats ? '0 : r_drop_cnt;

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_dropped  <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_dropped  <= w_drop || (r_dropped && !clr_stats);
         r_drop_cnt <= (w_drop && !(&w_cnt_base)) ? w_cnt_base + DROP_W'(1) : w_cnt_base;
      end
   end

   sampler_fifo2 u_fifo (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .i_push      (w_push),
      .i_dat       (w_delta),
      .i_pop       (delta_ready),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (delta_out)
   );

   assign delta_valid = !w_empty;
   assign dropped     = r_dropped;
   assign drop_count  = r_drop_cnt;
endmodule

// File: tb/tb_count_delta_sampler.sv
// Directed bench for count_delta_sampler with a queue-based reference model checked every cycle.
module tb_count_delta_sampler;
   localparam int PER = 4;

   logic        CLK = 1'b0;
   logic        ASYNCRESETN = 1'b0;
   logic [15:0] count_in = 16'd0;
   logic        en = 1'b0;
   logic        clr_stats = 1'b0;
   logic [15:0] delta_out;
   logic        delta_valid;
   logic        delta_ready = 1'b0;
   logic        dropped;
   logic [7:0]  drop_count;

   int total = 0;
   int bad = 0;
   bit auto_inc = 1'b0;

   // reference model state
   int          m_q[$];
   int          m_win;
   bit          m_primed;
   int          m_base;
   bit          m_dropped;
   int          m_dcnt;

   count_delta_sampler #(.PERIOD(PER)) dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .count_in    (count_in),
      .en          (en),
      .clr_stats   (clr_stats),
      .delta_out   (delta_out),
      .delta_valid (delta_valid),
      .delta_ready (delta_ready),
      .dropped     (dropped),
      .drop_count  (drop_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         m_q.delete();
         m_win = 0; m_primed = 0; m_base = 0; m_dropped = 0; m_dcnt = 0;
      end else begin
         int  pre_len;
         bit  do_pop, do_drop, do_push, tick;
         int  d;
         pre_len = m_q.size();
         do_pop  = (pre_len > 0) && delta_ready;
         tick    = en && (m_win == PER - 1);
         do_drop = 0; do_push = 0; d = 0;
         if (tick) begin
            if (m_primed) begin
               d = (int'(count_in) - m_base) & 16'hFFFF;
               if (pre_len < 2) do_push = 1; else do_drop = 1;
            end
            m_base = int'(count_in);
            m_primed = 1;
         end
         if (!en) begin
            m_win = 0; m_primed = 0;
         end else begin
            m_win = (m_win + 1) % PER;
         end
         if (do_pop) void'(m_q.pop_front());
         if (do_push) m_q.push_back(d);
         if (clr_stats) begin m_dropped = 0; m_dcnt = 0; end
         if (do_drop) begin
            m_dropped = 1;
            if (m_dcnt < 255) m_dcnt++;
         end
      end
   end

   always @(negedge CLK) begin
      check("valid", int'(delta_valid), int'(m_q.size() != 0));
      check("out", int'(delta_out), (m_q.size() != 0) ? m_q[0] : 0);
      check("dropped", int'(dropped), int'(m_dropped));
      check("drop_count", int'(drop_count), m_dcnt);
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (auto_inc) count_in = count_in + 16'd1;
      end
   endtask

   initial begin
      cyc(3);
      check("rst_valid", int'(delta_valid), 0);
      check("rst_out", int'(delta_out), 0);
      check("rst_dropped", int'(dropped), 0);
      check("rst_dcnt", int'(drop_count), 0);
      ASYNCRESETN = 1'b1;

      // basic rate
      en = 1; delta_ready = 1; auto_inc = 1;
      cyc(4);
      check("rate_first_tick_novalid", int'(delta_valid), 0);
      cyc(4);
      check("rate_valid", int'(delta_valid), 1);
      check("rate_delta", int'(delta_out), 4);
      cyc(1);
      check("rate_drained", int'(delta_valid), 0);
      cyc(6);

      // wrap
      auto_inc = 0; en = 0;
      cyc(1);
      en = 1; count_in = 16'hFFFE;
      cyc(4);
      count_in = 16'h0002;
      cyc(4);
      check("wrap_valid", int'(delta_valid), 1);
      check("wrap_delta", int'(delta_out), 4);
      en = 0;
      cyc(2);

      // backpressure
      delta_ready = 0; en = 1;
      count_in = 16'd100; cyc(4);
      count_in = 16'd103; cyc(4);
      count_in = 16'd110; cyc(4);
      count_in = 16'd130; cyc(4);
      en = 0;
      check("bp_head", int'(delta_out), 3);
      check("bp_dropped", int'(dropped), 1);
      check("bp_dcnt", int'(drop_count), 1);
      delta_ready = 1;
      cyc(1);
      check("bp_second", int'(delta_out), 7);
      cyc(1);
      check("bp_empty", int'(delta_valid), 0);

      // enable gap
      delta_ready = 0; en = 1;
      count_in = 16'd200; cyc(4);
      count_in = 16'd205; cyc(4);
      cyc(2);
      en = 0; cyc(5);
      check("gap_kept", int'(delta_out), 5);
      en = 1;
      count_in = 16'd300; cyc(4);
      check("gap_baseline_only", int'(delta_out), 5);
      count_in = 16'd310; cyc(4);
      en = 0;
      delta_ready = 1;
      cyc(1);
      check("gap_new_window", int'(delta_out), 10);
      cyc(1);
      check("gap_empty", int'(delta_valid), 0);

      // clear coinciding with drop, then saturation
      delta_ready = 0; en = 1; auto_inc = 1;
      cyc(23);
      clr_stats = 1;
      cyc(1);
      clr_stats = 0;
      check("clr_drop_dcnt", int'(drop_count), 1);
      check("clr_drop_sticky", int'(dropped), 1);
      cyc(1200);
      check("sat_dcnt", int'(drop_count), 255);
      cyc(40);
      check("sat_hold", int'(drop_count), 255);
      clr_stats = 1;
      cyc(1);
      clr_stats = 0;
      check("clr_alone_dcnt", int'(drop_count), 0);
      check("clr_alone_sticky", int'(dropped), 0);
      cyc(10);

      // asynchronous reset mid-window with data held
      check("pre_rst_valid", int'(delta_valid), 1);
      @(negedge CLK);
      #2 ASYNCRESETN = 1'b0;
      #1;
      check("arst_valid", int'(delta_valid), 0);
      check("arst_out", int'(delta_out), 0);
      check("arst_dcnt", int'(drop_count), 0);
      cyc(2);
      ASYNCRESETN = 1'b1;
      cyc(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
